// File: rtl/add_sub_4bit.sv
// Registered ripple-carry adder/subtractor built from an explicit full-adder chain.
// Define ADD_SUB_OVF_EN to add the registered signed-overflow output o_ovf.
module add_sub_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_s,
`ifdef ADD_SUB_OVF_EN
    output logic             o_ovf,
`endif
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Subtraction is A + ~B + 1: invert B and inject the select as carry-in.
    assign c[0] = i_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign bx[i]    = i_b[i] ^ i_s;
        assign sum_d[i] = i_a[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (i_a[i] & bx[i]) | (i_a[i] & c[i]) | (bx[i] & c[i]);
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= c[WIDTH];
        end
    end

    assign o_sum  = sum_q;
    assign o_cout = cout_q;

`ifdef ADD_SUB_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign o_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_sub_4bit.sv
// Self-checking bench for add_sub_4bit: arithmetic reference model, per-cycle compare,
// plus literal pins for the directed cases. Also covers o_ovf when ADD_SUB_OVF_EN is set.
module tb_add_sub_4bit;

    localparam int W = 4;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_s;
    logic [W-1:0] o_sum;
    logic         o_cout;
`ifdef ADD_SUB_OVF_EN
    logic         o_ovf;
`endif

    int vectors    = 0;
    int miscompares = 0;

    add_sub_4bit #(.WIDTH(W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_a   (i_a),
        .i_b   (i_b),
        .i_s   (i_s),
`ifdef ADD_SUB_OVF_EN
        .o_ovf (o_ovf),
`endif
        .o_sum (o_sum),
        .o_cout(o_cout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the registered outputs must hold after each edge.
    logic         model_valid = 1'b0;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    always @(posedge i_clk) begin
        int full, sa, sb, r;
        if (i_rst) begin
            exp_sum  = '0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
        end else begin
            if (i_s) full = int'(i_a) - int'(i_b) + (1 << W);
            else     full = int'(i_a) + int'(i_b);
            exp_sum  = W'(full % (1 << W));
            exp_cout = (full >= (1 << W));
            sa = (int'(i_a) >= (1 << (W-1))) ? int'(i_a) - (1 << W) : int'(i_a);
            sb = (int'(i_b) >= (1 << (W-1))) ? int'(i_b) - (1 << W) : int'(i_b);
            r  = i_s ? sa - sb : sa + sb;
            exp_ovf = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
        end
        model_valid = 1'b1;
    end

    always @(negedge i_clk) begin
        if (model_valid) begin
            check("model_sum", 32'(o_sum), 32'(exp_sum));
            check("model_cout", 32'(o_cout), 32'(exp_cout));
`ifdef ADD_SUB_OVF_EN
            check("model_ovf", 32'(o_ovf), 32'(exp_ovf));
`endif
        end
    end

    // Drive one cycle of inputs, then return at the following negedge.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic rst);
        i_a   = a;
        i_b   = b;
        i_s   = s;
        i_rst = rst;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic pin(input string name, input logic [W-1:0] sum, input logic cout);
        check({name, "_sum"}, 32'(o_sum), 32'(sum));
        check({name, "_cout"}, 32'(o_cout), 32'(cout));
    endtask

`ifdef ADD_SUB_OVF_EN
    task automatic pin_ovf(input string name, input logic ovf);
        check({name, "_ovf"}, 32'(o_ovf), 32'(ovf));
    endtask
`endif

    initial begin
        // Reset held for two edges with all-ones operands.
        step(4'hF, 4'hF, 1'b0, 1'b1); pin("rst0", 4'h0, 1'b0);
        step(4'hF, 4'hF, 1'b0, 1'b1); pin("rst1", 4'h0, 1'b0);
        step(4'hF, 4'hF, 1'b0, 1'b0); pin("rst_rel", 4'hE, 1'b1);

        step(4'h3, 4'h5, 1'b0, 1'b0); pin("add_3_5", 4'h8, 1'b0);
        step(4'h9, 4'h8, 1'b0, 1'b0); pin("add_9_8", 4'h1, 1'b1);
        step(4'hF, 4'h1, 1'b0, 1'b0); pin("add_F_1", 4'h0, 1'b1);

        step(4'h7, 4'h3, 1'b1, 1'b0); pin("sub_7_3", 4'h4, 1'b1);
        step(4'h3, 4'h7, 1'b1, 1'b0); pin("sub_3_7", 4'hC, 1'b0);
`ifdef ADD_SUB_OVF_EN
        pin_ovf("sub_3_7", 1'b0);
`endif
        step(4'h5, 4'h5, 1'b1, 1'b0); pin("sub_5_5", 4'h0, 1'b1);
        step(4'h0, 4'h1, 1'b1, 1'b0); pin("sub_0_1", 4'hF, 1'b0);
        step(4'h0, 4'h0, 1'b1, 1'b0); pin("sub_0_0", 4'h0, 1'b1);

`ifdef ADD_SUB_OVF_EN
        step(4'h7, 4'h1, 1'b0, 1'b0); pin_ovf("add_7_1", 1'b1);
        step(4'h8, 4'h1, 1'b1, 1'b0); pin_ovf("sub_8_1", 1'b1);
`endif

        // Back-to-back with the operation flipping every cycle.
        for (int r = 0; r < 2; r++) begin
            step(4'hA, 4'h3, 1'b0, 1'b0); pin("b2b_A+3", 4'hD, 1'b0);
            step(4'h2, 4'hA, 1'b1, 1'b0); pin("b2b_2-A", 4'h8, 1'b0);
            step(4'hA, 4'h3, 1'b1, 1'b0); pin("b2b_A-3", 4'h7, 1'b1);
            step(4'h2, 4'hA, 1'b0, 1'b0); pin("b2b_2+A", 4'hC, 1'b0);
        end

        // Single-cycle reset in the middle of an add stream.
        step(4'h1, 4'h1, 1'b0, 1'b0); pin("mid_pre", 4'h2, 1'b0);
        step(4'h1, 4'h2, 1'b0, 1'b1); pin("mid_rst", 4'h0, 1'b0);
        step(4'h1, 4'h2, 1'b0, 1'b0); pin("mid_post", 4'h3, 1'b0);

        // Random vectors, checked by the per-cycle model compare.
        for (int k = 0; k < 32; k++) begin
            step(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
